// File: rtl/digital_dco_pkg.sv
// Shared constants for the digitally controlled oscillator.
// Default widths, FCW limits, LFSR seed and LFSR step helper.
package digital_dco_pkg;

  localparam int ACC_W_D      = 24;
  localparam int CTRL_W_D     = 16;
  localparam int GAIN_SHIFT_D = 6;
  localparam int DIV_N_D      = 8;

  localparam logic [23:0] CENTER_FCW_D = 24'h100000;
  localparam logic [23:0] FCW_MIN_D    = 24'h040000;
  localparam logic [23:0] FCW_MAX_D    = 24'h200000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

endpackage

// File: rtl/dco_fb_div.sv
// Feedback divider: toggles fb_out every DIV_N/2 edge pulses.
// Ports: clk, rst (sync, high), edge_in (rise pulse), fb_out.
module dco_fb_div #(
  parameter int DIV_N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic edge_in,
  output logic fb_out
);

  localparam int HALF  = DIV_N / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fb_q, fb_d;

  always_comb begin
    cnt_d = cnt_q;
    fb_d  = fb_q;
    if (edge_in) begin
      if (cnt_q == CNT_W'(HALF - 1)) begin
        cnt_d = '0;
        fb_d  = ~fb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      fb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fb_q  <= fb_d;
    end
  end

  assign fb_out = fb_q;

endmodule

// File: rtl/digital_dco.sv
// Phase-accumulator DCO with clamped FCW, wrap-aligned updates.
// Ports: clk, rst, control_in/ctrl_valid/ctrl_ready, dco_out,
// fb_out, fcw_out, sat_hi, sat_lo. Option: DCO_DITHER_EN.
module digital_dco
  import digital_dco_pkg::*;
#(
  parameter int               ACC_W      = ACC_W_D,
  parameter int               CTRL_W     = CTRL_W_D,
  parameter logic [ACC_W-1:0] CENTER_FCW = CENTER_FCW_D,
  parameter int               GAIN_SHIFT = GAIN_SHIFT_D,
  parameter logic [ACC_W-1:0] FCW_MIN    = FCW_MIN_D,
  parameter logic [ACC_W-1:0] FCW_MAX    = FCW_MAX_D,
  parameter int               DIV_N      = DIV_N_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_in,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  output logic              dco_out,
  output logic              fb_out,
  output logic [ACC_W-1:0]  fcw_out,
  output logic              sat_hi,
  output logic              sat_lo
);

  localparam int EXT_W = ACC_W + CTRL_W + GAIN_SHIFT;
  localparam int PAD   = CTRL_W + GAIN_SHIFT;

  localparam logic signed [EXT_W-1:0] CTR_X =
    {{PAD{1'b0}}, CENTER_FCW};
  localparam logic signed [EXT_W-1:0] MAX_X =
    {{PAD{1'b0}}, FCW_MAX};
  localparam logic signed [EXT_W-1:0] MIN_X =
    {{PAD{1'b0}}, FCW_MIN};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_hi_q, pend_hi_d;
  logic             pend_lo_q, pend_lo_d;
  logic             sat_hi_q, sat_hi_d;
  logic             sat_lo_q, sat_lo_d;
  logic             dco_q, dco_d;

  logic signed [EXT_W-1:0] ctrl_ext;
  logic signed [EXT_W-1:0] cand;
  logic [ACC_W-1:0]        cand_fcw;
  logic                    cand_hi, cand_lo;
  logic [ACC_W:0]          sum;
  logic                    dith, wrap, accept, dco_rise;

`ifdef DCO_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign dith = lfsr_q[0];
`else
  assign dith = 1'b0;
`endif

  // Wide signed sum so extreme words clamp instead of wrapping.
  always_comb begin
    ctrl_ext = {{(EXT_W-CTRL_W){control_in[CTRL_W-1]}},
                control_in};
    cand     = CTR_X + (ctrl_ext <<< GAIN_SHIFT);
    cand_hi  = cand > MAX_X;
    cand_lo  = cand < MIN_X;
    cand_fcw = cand_hi ? FCW_MAX :
               cand_lo ? FCW_MIN :
               cand[ACC_W-1:0];
  end

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, fcw_q}
           + {{ACC_W{1'b0}}, dith};
    wrap   = sum[ACC_W];
    accept = ctrl_valid & ~pend_vld_q;

    acc_d      = sum[ACC_W-1:0];
    fcw_d      = fcw_q;
    sat_hi_d   = sat_hi_q;
    sat_lo_d   = sat_lo_q;
    pend_d     = pend_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_vld_d = pend_vld_q;

    // Only a word already pending before this wrap is applied;
    // one accepted now waits for the next wrap.
    if (wrap && pend_vld_q) begin
      fcw_d      = pend_q;
      sat_hi_d   = pend_hi_q;
      sat_lo_d   = pend_lo_q;
      pend_vld_d = 1'b0;
    end

    if (accept) begin
      pend_d     = cand_fcw;
      pend_hi_d  = cand_hi;
      pend_lo_d  = cand_lo;
      pend_vld_d = 1'b1;
    end

    dco_d    = acc_q[ACC_W-1];
    dco_rise = acc_q[ACC_W-1] & ~dco_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      fcw_q      <= CENTER_FCW;
      pend_q     <= '0;
      pend_hi_q  <= 1'b0;
      pend_lo_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      dco_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fcw_q      <= fcw_d;
      pend_q     <= pend_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      dco_q      <= dco_d;
    end
  end

  // Pulse coincides with the edge where dco_out goes high.
  dco_fb_div #(
    .DIV_N (DIV_N)
  ) u_fb_div (
    .clk     (clk),
    .rst     (rst),
    .edge_in (dco_rise),
    .fb_out  (fb_out)
  );

  assign ctrl_ready = ~pend_vld_q;
  assign dco_out    = dco_q;
  assign fcw_out    = fcw_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;

endmodule

// File: tb/tb_digital_dco.sv
// Directed bench for digital_dco with default parameters.
// Checks reset, FCW updates, clamping, wrap alignment, periods.
module tb_digital_dco;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] control_in = '0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready;
  logic        dco_out;
  logic        fb_out;
  logic [23:0] fcw_out;
  logic        sat_hi;
  logic        sat_lo;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dq[$];
  int fq[$];
  logic dco_p = 1'b0;
  logic fb_p  = 1'b0;

  digital_dco dut (
    .clk        (clk),
    .rst        (rst),
    .control_in (control_in),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .dco_out    (dco_out),
    .fb_out     (fb_out),
    .fcw_out    (fcw_out),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      dq.delete();
      fq.delete();
      dco_p <= 1'b0;
      fb_p  <= 1'b0;
    end else begin
      if (dco_out && !dco_p) dq.push_back(cyc);
      if (fb_out && !fb_p)   fq.push_back(cyc);
      dco_p <= dco_out;
      fb_p  <= fb_out;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ctrl_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int budget);
    control_in = w;
    ctrl_valid = 1'b1;
    for (int i = 0; i < 4 && ctrl_ready !== 1'b0; i++)
      @(negedge clk);
    ctrl_valid = 1'b0;
    check("accept", ctrl_ready, 1'b0);
    for (int i = 0; i < budget && ctrl_ready !== 1'b1; i++)
      @(negedge clk);
    check("apply", ctrl_ready, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", ctrl_ready, 1'b1);
    check("rst_dco", dco_out, 1'b0);
    check("rst_fb", fb_out, 1'b0);
    check("rst_fcw", fcw_out, 24'h100000);
    check("rst_sat", {sat_hi, sat_lo}, 2'b00);
    rst = 1'b0;

    // Free running at centre FCW.
    wait_cyc(200);
    check("dco_first", dq[0], 9);
    check("dco_per", dq[$] - dq[$-1], 16);
    check("fb_first", fq[0], 57);
    check("fb_per", fq[$] - fq[$-1], 128);
    check("fcw_ctr", fcw_out, 24'h100000);

    // Step +0x1000: applied at wrap on edge 208.
    control_in = 16'h1000;
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    check("b_rdy0", ctrl_ready, 1'b0);
    check("b_fcw_old", fcw_out, 24'h100000);
    wait_cyc(207);
    check("b_rdy_hold", ctrl_ready, 1'b0);
    check("b_fcw_hold", fcw_out, 24'h100000);
    wait_cyc(208);
    check("b_fcw_new", fcw_out, 24'h140000);
    check("b_rdy1", ctrl_ready, 1'b1);
    check("b_sat", {sat_hi, sat_lo}, 2'b00);
    wait_cyc(400);
    check("b_5per", dq[$] - dq[$-5], 64);

    // Word accepted in the wrap cycle waits one more wrap.
    do_reset();
    wait_cyc(15);
    control_in = 16'h1000;
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    check("w_rdy0", ctrl_ready, 1'b0);
    check("w_fcw16", fcw_out, 24'h100000);
    wait_cyc(20);
    control_in = 16'h2000;
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    wait_cyc(31);
    check("w_fcw31", fcw_out, 24'h100000);
    wait_cyc(32);
    check("w_fcw32", fcw_out, 24'h140000);
    check("w_rdy32", ctrl_ready, 1'b1);
    wait_cyc(46);
    check("w_ignored", fcw_out, 24'h140000);

    // Reset with a word pending and ctrl_valid high.
    wait_cyc(50);
    control_in = 16'h1000;
    ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    check("r_pend", ctrl_ready, 1'b0);
    rst = 1'b1;
    control_in = 16'h7FFF;
    ctrl_valid = 1'b1;
    @(negedge clk);
    check("r_rdy", ctrl_ready, 1'b1);
    check("r_fcw", fcw_out, 24'h100000);
    check("r_outs", {dco_out, fb_out, sat_hi, sat_lo}, 4'h0);
    rst = 1'b0;
    ctrl_valid = 1'b0;
    wait_cyc(17);
    check("r_disc", fcw_out, 24'h100000);
    check("r_rdy17", ctrl_ready, 1'b1);

    // Clamping.
    wait_cyc(20);
    send(16'h7FFF, 40);
    check("hi_fcw", fcw_out, 24'h200000);
    check("hi_flags", {sat_hi, sat_lo}, 2'b10);
    send(16'h8000, 40);
    check("lo_fcw", fcw_out, 24'h040000);
    check("lo_flags", {sat_hi, sat_lo}, 2'b01);
    repeat (200) @(negedge clk);
    check("lo_per", dq[$] - dq[$-1], 64);
    send(16'hF000, 100);
    check("neg_fcw", fcw_out, 24'h0C0000);
    check("neg_flags", {sat_hi, sat_lo}, 2'b00);
    send(16'h4001, 40);
    check("over_fcw", fcw_out, 24'h200000);
    check("over_flags", {sat_hi, sat_lo}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/digital_dco.md
DIGITAL_DCO -- requirements
Module: digital_dco

Interface
- REQ-001 SHALL have parameter ACC_W, default 24: phase accumulator width.
- REQ-002 SHALL have parameter CTRL_W, default 16: control word width.
- REQ-003 SHALL have parameter CENTER_FCW, default 24'h100000: free-running frequency control word (FCW).
- REQ-004 SHALL have parameter GAIN_SHIFT, default 6: left shift applied to the control word.
- REQ-005 SHALL have parameters FCW_MIN, default 24'h040000, and FCW_MAX, default 24'h200000: clamp limits.
- REQ-006 SHALL have parameter DIV_N, default 8, even and at least 2: feedback divide ratio.
- REQ-007 SHALL have the ports below, one per line:
  - clk  in  1  system clock; the single clock.
  - rst  in  1  reset, synchronous and active-high.
  - control_in  in  CTRL_W  signed two's-complement correction from the loop filter.
  - ctrl_valid  in  1  control_in is valid.
  - ctrl_ready  out  1  block can accept a control word.
  - dco_out  out  1  oscillator output.
  - fb_out  out  1  dco_out divided by DIV_N, for the phase detector.
  - fcw_out  out  ACC_W  FCW currently in use.
  - sat_hi  out  1  active FCW clamped at FCW_MAX.
  - sat_lo  out  1  active FCW clamped at FCW_MIN.

Function
- REQ-008 SHALL accept a control word on any cycle where ctrl_valid and ctrl_ready are both 1.
  - The accepted value is stored in a pending register.
  - ctrl_ready SHALL then read 0 on the following cycle.
- REQ-009 SHALL drive ctrl_ready as the inverse of the pending-valid flag.
- REQ-010 SHALL compute the candidate FCW as CENTER_FCW + (sign-extended control_in << GAIN_SHIFT).
  - Arithmetic is signed at ACC_W+CTRL_W+GAIN_SHIFT bits, so it never wraps.
- REQ-011 SHALL clamp the candidate FCW to [FCW_MIN, FCW_MAX].
  - sat_hi is set when the clamp hits FCW_MAX; sat_lo is set when it hits FCW_MIN.
- REQ-012 SHALL add the active FCW to the accumulator every cycle, modulo 2^ACC_W.
- REQ-013 SHALL move a pending FCW, with its sat flags, into the active FCW only in a cycle where the accumulator addition carries out (wrap).
  - The new FCW is used from the next cycle onward.
  - The pending flag clears in the same cycle.
- REQ-014 SHALL handle a word accepted in the same cycle as a wrap as follows: it is held pending and applied at the next wrap, not the current one.
- REQ-015 SHALL register dco_out as accumulator bit ACC_W-1, one cycle after the accumulator update.
- REQ-016 SHALL toggle fb_out on every (DIV_N/2)-th rising edge of dco_out, giving 50% duty.
  - The edge counter wraps from DIV_N/2-1 to 0.
- REQ-017 SHALL drive fcw_out as the registered active FCW.

Reset
- REQ-018 SHALL, on rst=1 at a clk edge, set the following:
  - accumulator = 0, active FCW = CENTER_FCW, pending cleared.
  - ctrl_ready = 1, dco_out = 0, fb_out = 0, divider count = 0, sat_hi = sat_lo = 0.
- REQ-019 SHALL, on rst asserted mid-operation, discard any pending word and ignore ctrl_valid during that cycle.
- REQ-020 SHALL leave all outputs at their reset values until the first clk edge with rst=0.

Configuration
- REQ-021 SHALL, when DCO_DITHER_EN is defined, include a 16-bit Fibonacci LFSR.
  - Taps 16,14,13,11; reset seed 16'hACE1; advances every cycle.
  - Its bit 0 is added to each accumulator increment.
- REQ-022 SHALL, without DCO_DITHER_EN, contain no LFSR and add the plain FCW each cycle.

Structure
- REQ-023 SHALL take its default widths, CENTER_FCW, FCW_MIN, FCW_MAX and LFSR seed constants from package digital_dco_pkg.
- REQ-024 SHALL implement the feedback divider as sub-module dco_fb_div, with parameter DIV_N and ports clk, rst, edge_in, fb_out.

Verification (defaults, dither off)
- REQ-025 Reset release with no ctrl_valid -> dco_out period 16 cycles, fcw_out=24'h100000, fb_out period 128 cycles.
- REQ-026 control_in=16'h1000 accepted -> ctrl_ready=0 until the next wrap -> fcw_out=24'h140000 -> dco_out period averages 12.8 cycles.
- REQ-027 control_in=16'h7FFF -> fcw_out=24'h200000 and sat_hi=1; control_in=16'h8000 -> fcw_out=24'h040000 and sat_lo=1.
- REQ-028 ctrl_valid in the same cycle as a wrap -> word held pending -> applied at the following wrap; a second ctrl_valid while ctrl_ready=0 -> ignored.
- REQ-029 rst for 1 cycle while a word is pending -> pending discarded, fcw_out=24'h100000, ctrl_ready=1 on the next cycle.
- REQ-030 DCO_DITHER_EN defined, control_in=0 -> average increment over 65535 cycles = 24'h100000 + 32768/65535 (±1 LSB).
